// File: rtl/md_hazard_ctrl.sv
// Hazard controller for the 5-stage MIPS pipeline: data-hazard stall/flush generation
// and sequencing of the multi-cycle mult/div unit.
module md_hazard_ctrl #(
  parameter int unsigned MULT_CYC = 5,
  parameter int unsigned DIV_CYC  = 10,
  parameter int unsigned CNT_W    = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [4:0] rs_D,
  input  logic [4:0] rt_D,
  input  logic [1:0] tuse_rs_D,
  input  logic [1:0] tuse_rt_D,
  input  logic       md_use_D,
  input  logic [4:0] A3_E,
  input  logic [1:0] tnew_E,
  input  logic [4:0] A3_M,
  input  logic [1:0] tnew_M,
  input  logic       md_start_E,
  input  logic       md_div_E,
  output logic       stall_o,
  output logic       flush_E_o,
  output logic       md_busy_o,
  output logic       md_done_o
);

  typedef enum logic {StIdle, StBusy} state_e;

  // Counter holds remaining busy cycles minus one, so BUSY lasts exactly N cycles.
  localparam logic [CNT_W-1:0] MultLoad = CNT_W'(MULT_CYC - 1);
  localparam logic [CNT_W-1:0] DivLoad  = CNT_W'(DIV_CYC - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;

  logic stall_rs, stall_rt, stall_md, stall_any;

  always_comb begin
    stall_rs = (rs_D != 5'd0) &&
               (((rs_D == A3_E) && (tuse_rs_D < tnew_E)) ||
                ((rs_D == A3_M) && (tuse_rs_D < tnew_M)));
    stall_rt = (rt_D != 5'd0) &&
               (((rt_D == A3_E) && (tuse_rt_D < tnew_E)) ||
                ((rt_D == A3_M) && (tuse_rt_D < tnew_M)));
    stall_md  = md_use_D && (md_busy_o || md_start_E);
    stall_any = stall_rs | stall_rt | stall_md;
    stall_o   = reset_n & stall_any;
    flush_E_o = reset_n & stall_any;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (md_start_E) begin
          state_d = StBusy;
          cnt_d   = md_div_E ? DivLoad : MultLoad;
        end
      end
      StBusy: begin
        // A start here is illegal and deliberately ignored.
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  assign md_busy_o = (state_q == StBusy);
  assign md_done_o = done_q;

endmodule

// File: tb/tb_md_hazard_ctrl.sv
// Directed-vector bench for md_hazard_ctrl with hand-computed expectations.
module tb_md_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [4:0] rs_D, rt_D, A3_E, A3_M;
  logic [1:0] tuse_rs_D, tuse_rt_D, tnew_E, tnew_M;
  logic       md_use_D, md_start_E, md_div_E;
  logic       stall_o, flush_E_o, md_busy_o, md_done_o;

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;

  md_hazard_ctrl #(.MULT_CYC(5), .DIV_CYC(10), .CNT_W(4)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .rs_D       (rs_D),
    .rt_D       (rt_D),
    .tuse_rs_D  (tuse_rs_D),
    .tuse_rt_D  (tuse_rt_D),
    .md_use_D   (md_use_D),
    .A3_E       (A3_E),
    .tnew_E     (tnew_E),
    .A3_M       (A3_M),
    .tnew_M     (tnew_M),
    .md_start_E (md_start_E),
    .md_div_E   (md_div_E),
    .stall_o    (stall_o),
    .flush_E_o  (flush_E_o),
    .md_busy_o  (md_busy_o),
    .md_done_o  (md_done_o)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rs_D = 5'd0; rt_D = 5'd0; tuse_rs_D = 2'd3; tuse_rt_D = 2'd3;
    md_use_D = 1'b0; A3_E = 5'd0; tnew_E = 2'd0; A3_M = 5'd0; tnew_M = 2'd0;
    md_start_E = 1'b0; md_div_E = 1'b0;
  endtask

  task automatic check_stall(input string tag, input logic exp);
    check_eq({tag, "_stall"}, {31'd0, stall_o}, {31'd0, exp});
    check_eq({tag, "_flush"}, {31'd0, flush_E_o}, {31'd0, exp});
  endtask

  task automatic check_md(input string tag, input logic busy, input logic done);
    check_eq({tag, "_busy"}, {31'd0, md_busy_o}, {31'd0, busy});
    check_eq({tag, "_done"}, {31'd0, md_done_o}, {31'd0, done});
  endtask

  initial begin
    logic seen_done;
    idle_inputs();
    reset_n = 1'b0;
    #1;
    // Hazard inputs during reset must not stall.
    rs_D = 5'd1; tuse_rs_D = 2'd0; A3_E = 5'd1; tnew_E = 2'd2; md_use_D = 1'b1;
    md_start_E = 1'b1;
    #1;
    check_stall("rst_gate", 1'b0);
    step();
    step();
    check_md("rst", 1'b0, 1'b0);
    idle_inputs();
    reset_n = 1'b1;
    #1;
    check_stall("idle", 1'b0);

    // 1: lw $1 in E, addu in D uses $1 at tuse=1.
    rs_D = 5'd1; tuse_rs_D = 2'd1; A3_E = 5'd1; tnew_E = 2'd2;
    #1;
    check_stall("lw_e", 1'b1);
    step();
    A3_E = 5'd0; tnew_E = 2'd0; A3_M = 5'd1; tnew_M = 2'd1;
    #1;
    check_stall("lw_m", 1'b0);
    // rt path against M with tuse 0.
    idle_inputs();
    rt_D = 5'd5; tuse_rt_D = 2'd0; A3_M = 5'd5; tnew_M = 2'd1;
    #1;
    check_stall("rt_m", 1'b1);
    tuse_rt_D = 2'd3; tnew_M = 2'd3;
    #1;
    check_stall("rt_unused", 1'b0);

    // 2: $0 never stalls.
    idle_inputs();
    rs_D = 5'd0; rt_D = 5'd0; tuse_rs_D = 2'd0; tuse_rt_D = 2'd0; A3_E = 5'd0; tnew_E = 2'd2;
    #1;
    check_stall("zero", 1'b0);

    // 3: mult issue with mflo in D.
    idle_inputs();
    md_start_E = 1'b1; md_div_E = 1'b0; md_use_D = 1'b1;
    #1;
    check_stall("mul_issue", 1'b1);
    check_md("mul_issue", 1'b0, 1'b0);
    step();
    md_start_E = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      check_md($sformatf("mul_b%0d", k), 1'b1, 1'b0);
      check_stall($sformatf("mul_b%0d", k), 1'b1);
      step();
    end
    check_md("mul_done", 1'b0, 1'b1);
    check_stall("mul_done", 1'b0);
    step();
    check_md("mul_after", 1'b0, 1'b0);

    // 4: div issue; a stray mult start mid-operation is ignored.
    idle_inputs();
    md_start_E = 1'b1; md_div_E = 1'b1;
    step();
    md_start_E = 1'b0; md_div_E = 1'b0;
    for (int k = 0; k < 10; k++) begin
      md_start_E = (k == 3);
      #1;
      check_md($sformatf("div_b%0d", k), 1'b1, 1'b0);
      step();
    end
    md_start_E = 1'b0;
    check_md("div_done", 1'b0, 1'b1);
    step();
    check_md("div_after", 1'b0, 1'b0);

    // 5: reset at cycle 3 of a div aborts with no done pulse.
    md_start_E = 1'b1; md_div_E = 1'b1;
    step();
    md_start_E = 1'b0;
    step();
    step();
    reset_n = 1'b0;
    step();
    check_md("abort", 1'b0, 1'b0);
    reset_n = 1'b1;
    seen_done = 1'b0;
    for (int k = 0; k < 12; k++) begin
      step();
      seen_done |= md_done_o | md_busy_o;
    end
    check_eq("abort_quiet", {31'd0, seen_done}, 32'd0);

    // 6: lw hazard on rs plus mflo while busy.
    idle_inputs();
    md_start_E = 1'b1;
    step();
    md_start_E = 1'b0; md_use_D = 1'b1;
    rs_D = 5'd3; tuse_rs_D = 2'd0; A3_E = 5'd3; tnew_E = 2'd2;
    for (int k = 0; k < 5; k++) begin
      #1;
      check_stall($sformatf("both_b%0d", k), 1'b1);
      step();
    end
    check_md("both_done", 1'b0, 1'b1);
    check_stall("both_data_only", 1'b1);
    A3_E = 5'd0; tnew_E = 2'd0;
    #1;
    check_stall("both_clear", 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
